// File: rtl/alu_seq16.sv
// alu_seq16 -- 16-bit add/sub/and/or sequencer built around an external
// combinational 8-bit ALU. Each command is processed as a low-byte pass and then
// a high-byte pass. The carry or borrow is chained between the two byte slices.
//
// Optional feature: define ALU_SEQ16_OVERLAP_EN to let a new command be accepted
// in the same cycle the previous result is consumed. This gives one command every
// three cycles instead of one every four.

module alu_seq16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  input  logic        cin,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_cin,
  output logic [1:0]  alu_sel,
  input  logic [7:0]  alu_out,
  input  logic        alu_cout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        cout,
  output logic        zero
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LO   = 2'b01,
    HI   = 2'b10,
    DONE = 2'b11
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  state_t      state;
  logic [1:0]  op_q;
  logic [15:0] opa_q;
  logic [15:0] opb_q;
  logic        cin_q;
  logic        carry_q;
  logic        accept;
  logic        consume;
  logic        arith_in;
  logic        arith_q;

  // Carry/borrow only has meaning for add and sub; logic ops force it to zero
  assign arith_in = (op == OP_ADD) || (op == OP_SUB);
  assign arith_q  = (op_q == OP_ADD) || (op_q == OP_SUB);

  assign accept  = in_valid && in_ready;
  assign consume = out_valid && out_ready;

  // Command acceptance: idle always, and optionally while a result is being consumed
  always_comb begin
    in_ready = (state == IDLE);
`ifdef ALU_SEQ16_OVERLAP_EN
    if (state == DONE) begin
      in_ready = out_ready;
    end
`endif
  end

  // Byte-slice drive to the external ALU, quiet (all zero) outside the two compute states
  always_comb begin
    alu_a   = 8'h00;
    alu_b   = 8'h00;
    alu_sel = 2'b00;
    alu_cin = 1'b0;
    case (state)
      LO: begin
        alu_a   = opa_q[7:0];
        alu_b   = opb_q[7:0];
        alu_sel = op_q;
        alu_cin = arith_q && cin_q;
      end
      HI: begin
        alu_a   = opa_q[15:8];
        alu_b   = opb_q[15:8];
        alu_sel = op_q;
        alu_cin = carry_q;
      end
      default: begin
        alu_a   = 8'h00;
        alu_b   = 8'h00;
        alu_sel = 2'b00;
        alu_cin = 1'b0;
      end
    endcase
  end

  // Sequencer: latch command, run low then high byte, hold result until consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= 2'b00;
      opa_q     <= 16'h0000;
      opb_q     <= 16'h0000;
      cin_q     <= 1'b0;
      carry_q   <= 1'b0;
      result    <= 16'h0000;
      cout      <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q  <= op;
            opa_q <= opa;
            opb_q <= opb;
            cin_q <= arith_in && cin;
            state <= LO;
          end
        end
        LO: begin
          result[7:0] <= alu_out;
          carry_q     <= arith_q && alu_cout;
          state       <= HI;
        end
        HI: begin
          result[15:8] <= alu_out;
          cout         <= arith_q && alu_cout;
          zero         <= (alu_out == 8'h00) && (result[7:0] == 8'h00);
          out_valid    <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          if (consume) begin
            out_valid <= 1'b0;
            if (accept) begin
              op_q  <= op;
              opa_q <= opa;
              opb_q <= opb;
              cin_q <= arith_in && cin;
              state <= LO;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq16.sv
// tb_alu_seq16 -- self-checking bench for alu_seq16. Provides the external 8-bit ALU
// and compares DUT behaviour against a whole-word arithmetic reference model.
// Honours ALU_SEQ16_OVERLAP_EN for the expected command period.

module tb_alu_seq16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [15:0] opa;
  logic [15:0] opb;
  logic        cin;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_cin;
  logic [1:0]  alu_sel;
  logic [7:0]  alu_out;
  logic        alu_cout;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        cout;
  logic        zero;
  logic [8:0]  alu_t;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef ALU_SEQ16_OVERLAP_EN
  localparam int PERIOD = 3;
`else
  localparam int PERIOD = 4;
`endif

  alu_seq16 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .opa       (opa),
    .opb       (opb),
    .cin       (cin),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_cin   (alu_cin),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .alu_cout  (alu_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  // External combinational byte ALU the sequencer drives
  always_comb begin
    case (alu_sel)
      2'b00:   alu_t = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
      2'b01:   alu_t = {1'b0, alu_a} - {1'b0, alu_b} - {8'h00, alu_cin};
      2'b10:   alu_t = {1'b0, alu_a & alu_b};
      default: alu_t = {1'b0, alu_a | alu_b};
    endcase
  end
  assign alu_out  = alu_t[7:0];
  assign alu_cout = alu_t[8];

  // Whole-word reference: returns {cout, result}
  function automatic logic [16:0] ref_model(input logic [1:0] o, input logic [15:0] a,
                                            input logic [15:0] b, input logic c);
    int s;
    logic [16:0] r;
    r = 17'h0;
    case (o)
      2'b00: begin
        s = int'(a) + int'(b) + int'(c);
        r = {(s > 65535), s[15:0]};
      end
      2'b01: begin
        s = int'(a) - int'(b) - int'(c);
        r = {(s < 0), s[15:0]};
      end
      2'b10: r = {1'b0, a & b};
      default: r = {1'b0, a | b};
    endcase
    return r;
  endfunction

  // Carry or borrow out of the low byte, which the ALU must see during the high byte
  function automatic logic low_carry(input logic [1:0] o, input logic [15:0] a,
                                     input logic [15:0] b, input logic c);
    if (o == 2'b00) return (int'(a[7:0]) + int'(b[7:0]) + int'(c)) > 255;
    if (o == 2'b01) return (int'(a[7:0]) - int'(b[7:0]) - int'(c)) < 0;
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = 2'b00; opa = 16'h0; opb = 16'h0; cin = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL reset_handshake got in_ready/out_valid=%b want 10", {in_ready, out_valid});
    end
    n_checks++;
    if ({cout, zero, result} !== 18'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs got cout=%b zero=%b result=%h want 0 0 0000", cout, zero, result);
    end
    n_checks++;
    if ({alu_a, alu_b, alu_sel, alu_cin} !== 19'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_alu_bus got a=%h b=%h sel=%b cin=%b want zeros", alu_a, alu_b, alu_sel, alu_cin);
    end
  endtask

  // One full command: accept, low byte, high byte, optional hold, consume
  task automatic test_transaction(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                                  input logic c, input int hold, input logic [16:0] exp);
    int waited;
    logic lc;
    lc = low_carry(o, a, b, c);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    waited = 0;
    while (!in_ready && waited < 10) begin
      tick();
      waited++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL accept_timeout got in_ready=%b want 1", in_ready);
    end
    op = o; opa = a; opb = b; cin = c; in_valid = 1'b1;
    tick();
    op = 2'($urandom_range(0, 3)); opa = 16'($urandom); opb = 16'($urandom);
    cin = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1));
    n_checks++;
    if ({alu_a, alu_b, alu_sel, alu_cin} !== {a[7:0], b[7:0], o, (o[1] ? 1'b0 : c)}) begin
      n_fail++;
      $display("[TB] FAIL lo_alu_bus got a=%h b=%h sel=%b cin=%b want %h %h %b %b",
               alu_a, alu_b, alu_sel, alu_cin, a[7:0], b[7:0], o, (o[1] ? 1'b0 : c));
    end
    n_checks++;
    if ({in_ready, out_valid} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL lo_handshake got in_ready/out_valid=%b want 00", {in_ready, out_valid});
    end
    tick();
    n_checks++;
    if ({alu_a, alu_b, alu_sel, alu_cin} !== {a[15:8], b[15:8], o, lc}) begin
      n_fail++;
      $display("[TB] FAIL hi_alu_bus got a=%h b=%h sel=%b cin=%b want %h %h %b %b",
               alu_a, alu_b, alu_sel, alu_cin, a[15:8], b[15:8], o, lc);
    end
    n_checks++;
    if ({in_ready, out_valid} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL hi_handshake got in_ready/out_valid=%b want 00", {in_ready, out_valid});
    end
    out_ready = 1'b0;
    tick();
    for (int i = 0; i <= hold; i++) begin
      opa = 16'($urandom); opb = 16'($urandom); in_valid = 1'b1;
      n_checks++;
      if ({out_valid, in_ready} !== 2'b10) begin
        n_fail++;
        $display("[TB] FAIL done_handshake cycle %0d got out_valid/in_ready=%b want 10", i, {out_valid, in_ready});
      end
      n_checks++;
      if ({cout, result} !== exp || zero !== (exp[15:0] == 16'h0)) begin
        n_fail++;
        $display("[TB] FAIL done_result cycle %0d op=%b a=%h b=%h cin=%b got cout=%b result=%h zero=%b want %b %h %b",
                 i, o, a, b, c, cout, result, zero, exp[16], exp[15:0], (exp[15:0] == 16'h0));
      end
      n_checks++;
      if ({alu_a, alu_b, alu_sel, alu_cin} !== 19'h0) begin
        n_fail++;
        $display("[TB] FAIL done_alu_bus got a=%h b=%h sel=%b cin=%b want zeros", alu_a, alu_b, alu_sel, alu_cin);
      end
      if (i < hold) tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL consume_handshake got out_valid/in_ready=%b want 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_directed();
    test_transaction(2'b00, 16'h00FF, 16'h0001, 1'b0, 0, {1'b0, 16'h0100});
    test_transaction(2'b00, 16'hFFFF, 16'h0001, 1'b0, 0, {1'b1, 16'h0000});
    test_transaction(2'b01, 16'h0000, 16'h0001, 1'b0, 0, {1'b1, 16'hFFFF});
    test_transaction(2'b10, 16'hF0F0, 16'h0FF0, 1'b1, 0, {1'b0, 16'h00F0});
    test_transaction(2'b11, 16'hA000, 16'h000A, 1'b1, 0, {1'b0, 16'hA00A});
    test_transaction(2'b00, 16'h00FF, 16'h0000, 1'b1, 0, {1'b0, 16'h0100});
    test_transaction(2'b01, 16'h1000, 16'h0001, 1'b1, 0, {1'b0, 16'h0FFE});
  endtask

  task automatic test_hold();
    test_transaction(2'b00, 16'h1234, 16'h4321, 1'b1, 5, {1'b0, 16'h5556});
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    for (int n = 0; n < 20; n++) begin
      o = 2'($urandom_range(0, 3));
      a = 16'($urandom);
      b = (n % 5 == 0) ? a : 16'($urandom);
      c = 1'($urandom_range(0, 1));
      test_transaction(o, a, b, c, int'($urandom_range(0, 2)), ref_model(o, a, b, c));
    end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; out_ready = 1'b0;
    op = 2'b00; opa = 16'h1234; opb = 16'h1111; cin = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, cout, zero, result} !== {2'b10, 18'h0}) begin
      n_fail++;
      $display("[TB] FAIL reset_in_hi got in_ready=%b out_valid=%b cout=%b zero=%b result=%h want 1 0 0 0 0000",
               in_ready, out_valid, cout, zero, result);
    end
    n_checks++;
    if ({alu_a, alu_b, alu_sel, alu_cin} !== 19'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_in_hi_alu_bus got a=%h b=%h sel=%b cin=%b want zeros", alu_a, alu_b, alu_sel, alu_cin);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL discarded_no_valid cycle %0d got out_valid=%b want 0", i, out_valid);
      end
    end
    in_valid = 1'b1; opa = 16'h00FF; opb = 16'h0001;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, result} !== {2'b10, 16'h0}) begin
      n_fail++;
      $display("[TB] FAIL reset_priority got in_ready=%b out_valid=%b result=%h want 1 0 0000", in_ready, out_valid, result);
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] q[$];
    logic [16:0] exp;
    int last;
    int seen;
    last = -1;
    seen = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 48; cyc++) begin
      op = 2'($urandom_range(0, 3)); opa = 16'($urandom); opb = 16'($urandom);
      cin = 1'($urandom_range(0, 1)); in_valid = 1'b1;
      if (in_ready) q.push_back(ref_model(op, opa, opb, cin));
      if (out_valid) begin
        exp = (q.size() > 0) ? q.pop_front() : 17'h0;
        n_checks++;
        if ({cout, result} !== exp) begin
          n_fail++;
          $display("[TB] FAIL b2b_result got cout=%b result=%h want %b %h", cout, result, exp[16], exp[15:0]);
        end
        if (last >= 0) begin
          n_checks++;
          if (cyc - last != PERIOD) begin
            n_fail++;
            $display("[TB] FAIL b2b_period got %0d cycles want %0d", cyc - last, PERIOD);
          end
        end
        last = cyc;
        seen++;
      end
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) begin
        exp = (q.size() > 0) ? q.pop_front() : 17'h0;
        n_checks++;
        if ({cout, result} !== exp) begin
          n_fail++;
          $display("[TB] FAIL b2b_drain_result got cout=%b result=%h want %b %h", cout, result, exp[16], exp[15:0]);
        end
        seen++;
      end
      tick();
    end
    n_checks++;
    if (q.size() != 0 || seen < 48 / PERIOD - 1) begin
      n_fail++;
      $display("[TB] FAIL b2b_count got %0d results with %0d pending want all drained", seen, q.size());
    end
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
